interrupt_dispatch_sequencer: RTL and testbench

//  Stateful interrupt arbiter and dispatch sequencer for the CPU control unit. Selects the highest-priority

---
 rtl/interrupt_dispatch_sequencer_pkg.sv | 19 +
 rtl/interrupt_dispatch_sequencer_prio.sv | 20 ++
 rtl/interrupt_dispatch_sequencer.sv | 134 +++++++++++++
 tb/tb_interrupt_dispatch_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/interrupt_dispatch_sequencer_pkg.sv
// rtl/interrupt_dispatch_sequencer_pkg.sv - shared types and vector arithmetic for interrupt dispatch
package cpu_int_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, PUSH_HI, PUSH_LO, JUMP} int_state_t;

  localparam int INT_VECTOR_W    = 16;
  localparam int INT_NUM_SOURCES = 5;
  localparam int INT_IDX_W       = $clog2(INT_NUM_SOURCES);

  // Vector arithmetic wraps at 16 bits, matching the PC width.
  function automatic logic [INT_VECTOR_W-1:0] int_vector(
    input logic [INT_VECTOR_W-1:0] base,
    input logic [INT_VECTOR_W-1:0] stride,
    input logic [7:0]              idx
  );
    return base + stride * {8'h00, idx};
  endfunction

endpackage

// File: rtl/interrupt_dispatch_sequencer_prio.sv
// rtl/interrupt_dispatch_sequencer_prio.sv - combinational lowest-index-wins priority encoder
module int_priority_encoder #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] i_Pend,
  output logic [W-1:0] o_Sel,
  output logic         o_Any
);

  always_comb begin
    o_Sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_Pend[i]) o_Sel = W'(i);
    end
  end

  assign o_Any = |i_Pend;

endmodule

// File: rtl/interrupt_dispatch_sequencer.sv
// rtl/interrupt_dispatch_sequencer.sv - interrupt arbiter and multi-M-cycle dispatch sequencer
// Optional INT_DISPATCH_CANCEL_EN: re-select the source after the high-byte push, allowing a cancelled dispatch.
module interrupt_dispatch_sequencer
  import cpu_int_pkg::*;
#(
  parameter int                      NUM_SOURCES   = 5,
  parameter logic [INT_VECTOR_W-1:0] VECTOR_BASE   = 16'h0040,
  parameter int                      VECTOR_STRIDE = 8,
  parameter int                      WAIT_CYCLES   = 2
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset_n,
  input  logic                    i_M_Step,
  input  logic                    i_Boundary,
  input  logic                    i_IME,
  input  logic [NUM_SOURCES-1:0]  i_IF,
  input  logic [NUM_SOURCES-1:0]  i_IE,
  output logic                    o_Busy,
  output logic                    o_Wake,
  output logic                    o_Push_Hi,
  output logic                    o_Push_Lo,
  output logic                    o_Set_PC,
  output logic [INT_VECTOR_W-1:0] o_Vector,
  output logic [NUM_SOURCES-1:0]  o_Ack,
  output logic                    o_DI,
  output logic                    o_IR_Fetch
);

  localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [NUM_SOURCES-1:0] w_pend;
  logic [IDX_W-1:0]       w_sel;
  logic                   w_any;
  logic                   w_trigger;

  int_state_t       r_state;
  logic [1:0]       r_wait_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;

  assign w_pend    = i_IF & i_IE;
  assign w_trigger = i_IME & w_any & i_Boundary & i_M_Step;
  assign o_Wake    = w_any;

  int_priority_encoder #(
    .N (NUM_SOURCES),
    .W (IDX_W)
  ) u_prio (
    .i_Pend (w_pend),
    .o_Sel  (w_sel),
    .o_Any  (w_any)
  );

  // Outputs are registered alongside the state so each micro-op spans exactly its M-cycle.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 2'd0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      o_Busy     <= 1'b0;
      o_Push_Hi  <= 1'b0;
      o_Push_Lo  <= 1'b0;
      o_Set_PC   <= 1'b0;
      o_Vector   <= '0;
      o_Ack      <= '0;
      o_DI       <= 1'b0;
      o_IR_Fetch <= 1'b0;
    end else begin
      o_DI  <= 1'b0;
      o_Ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_idx      <= w_sel;
            r_valid    <= 1'b1;
            r_wait_cnt <= 2'd0;
            o_DI       <= 1'b1;
            o_Busy     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state   <= PUSH_HI;
              o_Push_Hi <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_M_Step) begin
            if (r_wait_cnt == 2'(WAIT_CYCLES - 1)) begin
              r_state   <= PUSH_HI;
              o_Push_Hi <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + 2'd1;
            end
          end
        end
        PUSH_HI: begin
          if (i_M_Step) begin
            r_state   <= PUSH_LO;
            o_Push_Hi <= 1'b0;
            o_Push_Lo <= 1'b1;
`ifdef INT_DISPATCH_CANCEL_EN
            r_idx   <= w_sel;
            r_valid <= w_any;
`endif
          end
        end
        PUSH_LO: begin
          if (i_M_Step) begin
            r_state    <= JUMP;
            o_Push_Lo  <= 1'b0;
            o_Set_PC   <= 1'b1;
            o_IR_Fetch <= 1'b1;
            o_Vector   <= r_valid ? int_vector(VECTOR_BASE, INT_VECTOR_W'(VECTOR_STRIDE), 8'(r_idx))
                                  : '0;
          end
        end
        JUMP: begin
          if (i_M_Step) begin
            r_state    <= IDLE;
            o_Set_PC   <= 1'b0;
            o_IR_Fetch <= 1'b0;
            o_Vector   <= '0;
            o_Busy     <= 1'b0;
            if (r_valid) o_Ack <= NUM_SOURCES'(1) << r_idx;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_dispatch_sequencer.sv
// tb/tb_interrupt_dispatch_sequencer.sv - directed self-checking bench for interrupt_dispatch_sequencer
module tb_interrupt_dispatch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_step, boundary, ime, p_ime;
  logic [4:0]  int_if, int_ie;
  logic [7:0]  p_if, p_ie;

  logic        busy, wake, push_hi, push_lo, set_pc, di, ir_fetch;
  logic [15:0] vector;
  logic [4:0]  ack;

  logic        p_busy, p_wake, p_push_hi, p_push_lo, p_set_pc, p_di, p_ir_fetch;
  logic [15:0] p_vector;
  logic [7:0]  p_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  interrupt_dispatch_sequencer dut (
    .i_Clk      (clk),
    .i_Reset_n  (rst_n),
    .i_M_Step   (m_step),
    .i_Boundary (boundary),
    .i_IME      (ime),
    .i_IF       (int_if),
    .i_IE       (int_ie),
    .o_Busy     (busy),
    .o_Wake     (wake),
    .o_Push_Hi  (push_hi),
    .o_Push_Lo  (push_lo),
    .o_Set_PC   (set_pc),
    .o_Vector   (vector),
    .o_Ack      (ack),
    .o_DI       (di),
    .o_IR_Fetch (ir_fetch)
  );

  interrupt_dispatch_sequencer #(
    .NUM_SOURCES   (8),
    .VECTOR_BASE   (16'h0040),
    .VECTOR_STRIDE (16),
    .WAIT_CYCLES   (0)
  ) dut_p (
    .i_Clk      (clk),
    .i_Reset_n  (rst_n),
    .i_M_Step   (m_step),
    .i_Boundary (boundary),
    .i_IME      (p_ime),
    .i_IF       (p_if),
    .i_IE       (p_ie),
    .o_Busy     (p_busy),
    .o_Wake     (p_wake),
    .o_Push_Hi  (p_push_hi),
    .o_Push_Lo  (p_push_lo),
    .o_Set_PC   (p_set_pc),
    .o_Vector   (p_vector),
    .o_Ack      (p_ack),
    .o_DI       (p_di),
    .o_IR_Fetch (p_ir_fetch)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One M-cycle: three idle clocks then a one-clock step strobe; returns #1 after the step edge.
  task automatic m_end();
    m_step = 1'b0;
    repeat (3) tick();
    m_step = 1'b1;
    tick();
    m_step = 1'b0;
  endtask

  // Full WAIT_CYCLES=2 dispatch on dut, starting from the trigger M-cycle.
  task automatic dispatch(input string tag, input logic [15:0] exp_vec, input logic [4:0] exp_ack,
                          input bit clear_ie);
    m_end();
    check_eq({tag, "_di"}, {31'd0, di}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "_m1_hi"}, {31'd0, push_hi}, 32'd0);
    ime = 1'b0;
    boundary = 1'b0;
    tick();
    check_eq({tag, "_di_pulse"}, {31'd0, di}, 32'd0);
    m_end();
    check_eq({tag, "_m2_hi"}, {31'd0, push_hi}, 32'd0);
    m_end();
    check_eq({tag, "_m3_hi"}, {31'd0, push_hi}, 32'd1);
    if (clear_ie) int_ie = 5'h00;
    m_end();
    check_eq({tag, "_m4_lo"}, {30'd0, push_hi, push_lo}, 32'd1);
    m_end();
    check_eq({tag, "_m5_setpc"}, {30'd0, set_pc, ir_fetch}, 32'd3);
    check_eq({tag, "_vec"}, {16'd0, vector}, {16'd0, exp_vec});
    m_end();
    check_eq({tag, "_ack"}, {27'd0, ack}, {27'd0, exp_ack});
    check_eq({tag, "_idle"}, {30'd0, busy, set_pc}, 32'd0);
    tick();
    check_eq({tag, "_ack_pulse"}, {27'd0, ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] seen;
    rst_n = 1'b0; m_step = 1'b0; boundary = 1'b0; ime = 1'b0; p_ime = 1'b0;
    int_if = 5'h00; int_ie = 5'h00; p_if = 8'h00; p_ie = 8'h00;
    repeat (3) tick();
    check_eq("reset_outs", {busy, push_hi, push_lo, set_pc, vector, ack, di, ir_fetch, wake}, 32'd0);
    int_if = 5'h01; int_ie = 5'h01;
    #1;
    check_eq("reset_wake", {31'd0, wake}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Single request
    ime = 1'b1; boundary = 1'b1;
    dispatch("single", 16'h0040, 5'h01, 1'b0);
    int_if = 5'h00;

    // Priority: bit 2 wins over bit 4
    int_if = 5'h14; int_ie = 5'h1F; ime = 1'b1; boundary = 1'b1;
    dispatch("prio", 16'h0050, 5'h04, 1'b0);
    int_if = int_if & ~5'h04;
    m_end();
    check_eq("prio_left_busy", {31'd0, busy}, 32'd0);
    check_eq("prio_left_wake", {31'd0, wake}, 32'd1);

    // Gating: IME low never dispatches
    int_if = 5'h02; int_ie = 5'h02; ime = 1'b0; boundary = 1'b1;
    seen = 32'd0;
    for (int i = 0; i < 10; i++) begin
      m_end();
      seen = seen | {27'd0, busy, push_hi, push_lo, set_pc, di};
    end
    check_eq("gate_quiet", seen, 32'd0);
    check_eq("gate_wake", {31'd0, wake}, 32'd1);

    // Reset during PUSH_LO
    int_if = 5'h01; int_ie = 5'h01; ime = 1'b1; boundary = 1'b1;
    m_end();
    ime = 1'b0; boundary = 1'b0;
    m_end(); m_end(); m_end();
    check_eq("rst_in_lo", {31'd0, push_lo}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", {busy, push_hi, push_lo, set_pc, vector, ack, di, ir_fetch}, 32'd0);
    tick();
    check_eq("rst_edge", {busy, push_hi, push_lo, set_pc, vector, ack, di, ir_fetch}, 32'd0);
    rst_n = 1'b1;
    tick();
    ime = 1'b1; boundary = 1'b1;
    dispatch("rst_fresh", 16'h0040, 5'h01, 1'b0);

    // IE cleared just before the PUSH_HI step
    int_if = 5'h01; int_ie = 5'h01; ime = 1'b1; boundary = 1'b1;
`ifdef INT_DISPATCH_CANCEL_EN
    dispatch("cancel", 16'h0000, 5'h00, 1'b1);
`else
    dispatch("cancel", 16'h0040, 5'h01, 1'b1);
`endif
    int_if = 5'h00; int_ie = 5'h00;

    // Parameterised instance: 8 sources, stride 16, no wait
    p_if = 8'h80; p_ie = 8'h80; p_ime = 1'b1; boundary = 1'b1;
    m_end();
    p_ime = 1'b0; boundary = 1'b0;
    check_eq("p_trig", {29'd0, p_di, p_busy, p_push_hi}, 32'd7);
    m_end();
    check_eq("p_lo", {30'd0, p_push_hi, p_push_lo}, 32'd1);
    m_end();
    check_eq("p_setpc", {31'd0, p_set_pc}, 32'd1);
    check_eq("p_vec", {16'd0, p_vector}, 32'h0000_00B0);
    m_end();
    check_eq("p_ack", {24'd0, p_ack}, 32'h80);
    check_eq("p_idle", {31'd0, p_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
